// File: rtl/unpool2_module.sv
// 2x2 nearest-neighbour upsampler: each input word is emitted twice, then the buffered row is replayed.
// Optional build macro UNPOOL_ZERO_FILL_EN selects zero-insertion upsampling instead of replication.
module unpool2_module #(
    parameter int DATA_W = 96,
    parameter int COL_IN = 8,
    parameter int ROW_IN = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              ready_in,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              unpool_end
);

    localparam int CW = (COL_IN > 1) ? $clog2(COL_IN) : 1;
    localparam int RW = (ROW_IN > 1) ? $clog2(ROW_IN) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(COL_IN - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROW_IN - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FILL   = 2'd1,
        S_REPLAY = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [CW-1:0]     r_wcol, w_wcol_nxt;
    logic [CW-1:0]     r_rcol, w_rcol_nxt;
    logic [RW-1:0]     r_row, w_row_nxt;
    logic              r_dup, w_dup_nxt;
    logic [DATA_W-1:0] r_data_out, w_data_nxt;
    logic              r_valid_out, w_valid_nxt;
    logic              r_end, w_end_nxt;
    logic              w_ready;
    logic              w_hs;
`ifndef UNPOOL_ZERO_FILL_EN
    logic [DATA_W-1:0] r_buf [COL_IN];
    logic              w_buf_we;
`endif

    assign w_ready    = (r_state == S_FILL) && !r_dup && en;
    assign w_hs       = w_ready && valid_in;
    assign ready_in   = w_ready;
    assign data_out   = r_data_out;
    assign valid_out  = r_valid_out;
    assign unpool_end = r_end;

    // State and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_wcol  <= {CW{1'b0}};
            r_rcol  <= {CW{1'b0}};
            r_row   <= {RW{1'b0}};
            r_dup   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_wcol  <= w_wcol_nxt;
            r_rcol  <= w_rcol_nxt;
            r_row   <= w_row_nxt;
            r_dup   <= w_dup_nxt;
        end
    end

    // Next-state and counter logic; dropping en discards the frame from any state
    always_comb begin
        w_state_nxt = r_state;
        w_wcol_nxt  = r_wcol;
        w_rcol_nxt  = r_rcol;
        w_row_nxt   = r_row;
        w_dup_nxt   = r_dup;
        if (!en) begin
            w_state_nxt = S_IDLE;
            w_wcol_nxt  = {CW{1'b0}};
            w_rcol_nxt  = {CW{1'b0}};
            w_row_nxt   = {RW{1'b0}};
            w_dup_nxt   = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_FILL;
                    w_wcol_nxt  = {CW{1'b0}};
                    w_rcol_nxt  = {CW{1'b0}};
                    w_row_nxt   = {RW{1'b0}};
                    w_dup_nxt   = 1'b0;
                end
                S_FILL: begin
                    if (!r_dup) begin
                        w_dup_nxt = w_hs;
                    end else begin
                        w_dup_nxt = 1'b0;
                        if (r_wcol == COL_LAST) begin
                            w_wcol_nxt  = {CW{1'b0}};
                            w_rcol_nxt  = {CW{1'b0}};
                            w_state_nxt = S_REPLAY;
                        end else begin
                            w_wcol_nxt = r_wcol + 1'b1;
                        end
                    end
                end
                S_REPLAY: begin
                    w_dup_nxt = ~r_dup;
                    if (r_dup) begin
                        if (r_rcol == COL_LAST) begin
                            w_rcol_nxt = {CW{1'b0}};
                            if (r_row == ROW_LAST) begin
                                w_state_nxt = S_DONE;
                            end else begin
                                w_row_nxt   = r_row + 1'b1;
                                w_wcol_nxt  = {CW{1'b0}};
                                w_state_nxt = S_FILL;
                            end
                        end else begin
                            w_rcol_nxt = r_rcol + 1'b1;
                        end
                    end else begin
                        w_rcol_nxt = r_rcol;
                    end
                end
                S_DONE: begin
                    w_state_nxt = S_IDLE;
                    w_wcol_nxt  = {CW{1'b0}};
                    w_rcol_nxt  = {CW{1'b0}};
                    w_row_nxt   = {RW{1'b0}};
                    w_dup_nxt   = 1'b0;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Next values of the registered outputs and the line-buffer write strobe
    always_comb begin
        w_data_nxt  = r_data_out;
        w_valid_nxt = 1'b0;
        w_end_nxt   = 1'b0;
`ifndef UNPOOL_ZERO_FILL_EN
        w_buf_we    = 1'b0;
`endif
        if (en) begin
            case (r_state)
                S_FILL: begin
                    if (!r_dup) begin
                        if (w_hs) begin
                            w_data_nxt  = data_in;
                            w_valid_nxt = 1'b1;
`ifndef UNPOOL_ZERO_FILL_EN
                            w_buf_we    = 1'b1;
`endif
                        end else begin
                            w_valid_nxt = 1'b0;
                        end
                    end else begin
                        w_valid_nxt = 1'b1;
`ifdef UNPOOL_ZERO_FILL_EN
                        w_data_nxt  = {DATA_W{1'b0}};
`endif
                    end
                end
                S_REPLAY: begin
                    w_valid_nxt = 1'b1;
`ifdef UNPOOL_ZERO_FILL_EN
                    w_data_nxt  = {DATA_W{1'b0}};
`else
                    w_data_nxt  = r_buf[r_rcol];
`endif
                end
                S_DONE: begin
                    w_end_nxt = 1'b1;
                end
                default: begin
                    w_valid_nxt = 1'b0;
                end
            endcase
        end else begin
            w_valid_nxt = 1'b0;
        end
    end

    // Registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_out  <= {DATA_W{1'b0}};
            r_valid_out <= 1'b0;
            r_end       <= 1'b0;
        end else begin
            r_data_out  <= w_data_nxt;
            r_valid_out <= w_valid_nxt;
            r_end       <= w_end_nxt;
        end
    end

`ifndef UNPOOL_ZERO_FILL_EN
    // Line buffer holds the current input row for the replay pass; contents need no reset
    always_ff @(posedge clk) begin
        if (w_buf_we) begin
            r_buf[r_wcol] <= data_in;
        end
    end
`endif

endmodule

// File: tb/tb_unpool2_module.sv
// Self-checking bench for unpool2_module: expected output words are queued at each
// accepted input and compared against the words collected from valid_out.
module tb_unpool2_module;

    localparam int DATA_W = 96;
    localparam int COL_IN = 8;
    localparam int ROW_IN = 8;
    localparam int NWORDS = COL_IN * ROW_IN;
    localparam int NOUT   = 4 * COL_IN * ROW_IN;
`ifdef UNPOOL_ZERO_FILL_EN
    localparam bit ZF = 1'b1;
`else
    localparam bit ZF = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              en;
    logic              valid_in;
    logic [DATA_W-1:0] data_in;
    logic              ready_in;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic              unpool_end;

    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] obs_q[$];
    logic [DATA_W-1:0] row_buf[COL_IN];

    int total = 0;
    int bad = 0;
    int obs_rd = 0;
    int cyc_cnt = 0;
    int end_cnt = 0;
    int end_cyc = 0;
    int last_valid_cyc = 0;

    unpool2_module #(.DATA_W(DATA_W), .COL_IN(COL_IN), .ROW_IN(ROW_IN)) dut (
        .clk(clk), .rst(rst), .en(en), .valid_in(valid_in), .data_in(data_in),
        .ready_in(ready_in), .data_out(data_out), .valid_out(valid_out),
        .unpool_end(unpool_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Collect every output word and the end pulses, away from the rising edge
    always @(negedge clk) begin
        cyc_cnt++;
        if (valid_out === 1'b1) begin
            obs_q.push_back(data_out);
            last_valid_cyc = cyc_cnt;
        end
        if (unpool_end === 1'b1) begin
            end_cnt++;
            end_cyc = cyc_cnt;
        end
    end

    function automatic logic [DATA_W-1:0] word(input int k);
        logic [7:0] b;
        b = k[7:0];
        return {12{b}};
    endfunction

    task automatic push_word(input int k);
        logic [DATA_W-1:0] w;
        int c;
        w = word(k);
        c = k % COL_IN;
        exp_q.push_back(w);
        exp_q.push_back(ZF ? {DATA_W{1'b0}} : w);
        row_buf[c] = w;
        if (c == COL_IN - 1) begin
            for (int c2 = 0; c2 < COL_IN; c2++) begin
                exp_q.push_back(ZF ? {DATA_W{1'b0}} : row_buf[c2]);
                exp_q.push_back(ZF ? {DATA_W{1'b0}} : row_buf[c2]);
            end
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        en = 1'b0;
        valid_in = 1'b0;
        data_in = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        exp_q.delete();
        obs_rd = obs_q.size();
    endtask

    task automatic drive_frame(input bit rnd, output bit to);
        int k;
        int cyc;
        k = 0;
        cyc = 0;
        en = 1'b1;
        while (k < NWORDS && cyc < 3000) begin
            @(negedge clk);
            data_in = word(k);
            valid_in = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            #1;
            if (ready_in && valid_in) begin
                push_word(k);
                k++;
            end
            cyc++;
        end
        @(negedge clk);
        valid_in = 1'b0;
        to = (k < NWORDS);
    endtask

    task automatic wait_end(input int base, output bit to);
        to = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #1;
            if (end_cnt > base) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en = 1'b0;
        valid_in = 1'b0;
        data_in = '0;
        repeat (2) @(negedge clk);
        #1;
        total++; if (data_out !== '0) begin bad++; $display("FAIL reset_data: got %h want 0", data_out); end
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid_out); end
        total++; if (ready_in !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", ready_in); end
        total++; if (unpool_end !== 1'b0) begin bad++; $display("FAIL reset_end: got %b want 0", unpool_end); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        total++; if (ready_in !== 1'b0 || valid_out !== 1'b0) begin
            bad++; $display("FAIL idle_en_low: ready=%b valid=%b want 0 0", ready_in, valid_out);
        end
    endtask

    task automatic test_basic_frame();
        bit to;
        int base_end;
        int n;
        apply_reset();
        base_end = end_cnt;
        drive_frame(1'b0, to);
        total++; if (to) begin bad++; $display("FAIL basic_feed_timeout: input words not all accepted"); end
        wait_end(base_end, to);
        total++; if (to) begin bad++; $display("FAIL basic_end_timeout: no unpool_end seen"); end
        repeat (3) @(negedge clk);
        #1;
        en = 1'b0;
        n = obs_q.size() - obs_rd;
        total++; if (n !== NOUT || exp_q.size() !== NOUT) begin
            bad++; $display("FAIL basic_count: got %0d words want %0d (queued %0d)", n, NOUT, exp_q.size());
        end
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            total++; if (obs_q[obs_rd + i] !== exp_q[i]) begin
                bad++; $display("FAIL basic_word %0d: got %h want %h", i, obs_q[obs_rd + i], exp_q[i]);
            end
        end
        total++; if (end_cnt - base_end !== 1) begin bad++; $display("FAIL basic_end_count: got %0d want 1", end_cnt - base_end); end
        total++; if (end_cyc !== last_valid_cyc + 1) begin
            bad++; $display("FAIL basic_end_timing: end at %0d want %0d", end_cyc, last_valid_cyc + 1);
        end
        obs_rd = obs_q.size();
    endtask

    task automatic test_handshake();
        int k;
        int n;
        logic exp_r;
        apply_reset();
        k = 0;
        @(negedge clk);
        en = 1'b1;
        valid_in = 1'b1;
        data_in = word(0);
        #1;
        total++; if (ready_in !== 1'b0) begin bad++; $display("FAIL hs_idle_ready: got %b want 0", ready_in); end
        for (int i = 0; i < 2 * 4 * COL_IN; i++) begin
            @(negedge clk);
            data_in = word(k);
            #1;
            exp_r = ((i % (4 * COL_IN)) < 2 * COL_IN) && (i % 2 == 0);
            total++; if (ready_in !== exp_r) begin
                bad++; $display("FAIL hs_ready cycle %0d: got %b want %b", i, ready_in, exp_r);
            end
            if (ready_in && valid_in) begin
                push_word(k);
                k++;
            end
        end
        @(negedge clk);
        en = 1'b0;
        valid_in = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total++; if (k !== 2 * COL_IN) begin bad++; $display("FAIL hs_accepted: got %0d want %0d", k, 2 * COL_IN); end
        n = obs_q.size() - obs_rd;
        total++; if (n !== exp_q.size()) begin bad++; $display("FAIL hs_count: got %0d words want %0d", n, exp_q.size()); end
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            total++; if (obs_q[obs_rd + i] !== exp_q[i]) begin
                bad++; $display("FAIL hs_word %0d: got %h want %h", i, obs_q[obs_rd + i], exp_q[i]);
            end
        end
        obs_rd = obs_q.size();
    endtask

    task automatic test_bubbles();
        bit to;
        int base_end;
        int n;
        apply_reset();
        base_end = end_cnt;
        drive_frame(1'b1, to);
        total++; if (to) begin bad++; $display("FAIL bub_feed_timeout: input words not all accepted"); end
        wait_end(base_end, to);
        total++; if (to) begin bad++; $display("FAIL bub_end_timeout: no unpool_end seen"); end
        repeat (3) @(negedge clk);
        #1;
        en = 1'b0;
        n = obs_q.size() - obs_rd;
        total++; if (n !== NOUT) begin bad++; $display("FAIL bub_count: got %0d words want %0d", n, NOUT); end
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            total++; if (obs_q[obs_rd + i] !== exp_q[i]) begin
                bad++; $display("FAIL bub_word %0d: got %h want %h", i, obs_q[obs_rd + i], exp_q[i]);
            end
        end
        total++; if (end_cnt - base_end !== 1) begin bad++; $display("FAIL bub_end_count: got %0d want 1", end_cnt - base_end); end
        obs_rd = obs_q.size();
    endtask

    task automatic test_abort();
        int k;
        int n;
        int base_end;
        int abort_cyc;
        apply_reset();
        k = 0;
        abort_cyc = 3 * 4 * COL_IN + 2 * COL_IN + 5;
        @(negedge clk);
        en = 1'b1;
        valid_in = 1'b1;
        for (int i = 0; i < abort_cyc; i++) begin
            @(negedge clk);
            data_in = word(k);
            #1;
            if (ready_in && valid_in) begin
                push_word(k);
                k++;
            end
        end
        base_end = end_cnt;
        @(negedge clk);
        en = 1'b0;
        valid_in = 1'b0;
        @(negedge clk);
        #1;
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL abort_valid: got %b want 0", valid_out); end
        n = obs_q.size() - obs_rd;
        total++; if (n !== abort_cyc) begin bad++; $display("FAIL abort_count: got %0d words want %0d", n, abort_cyc); end
        if (n > 0 && n <= exp_q.size()) begin
            total++; if (obs_q[obs_rd + n - 1] !== exp_q[n - 1]) begin
                bad++; $display("FAIL abort_last_word: got %h want %h", obs_q[obs_rd + n - 1], exp_q[n - 1]);
            end
        end
        repeat (5) @(negedge clk);
        #1;
        total++; if (end_cnt !== base_end) begin bad++; $display("FAIL abort_end: got %0d pulses want 0", end_cnt - base_end); end
        @(negedge clk);
        en = 1'b1;
        valid_in = 1'b1;
        data_in = word(0);
        #1;
        total++; if (ready_in !== 1'b0) begin bad++; $display("FAIL restart_idle_ready: got %b want 0", ready_in); end
        @(negedge clk);
        #1;
        total++; if (ready_in !== 1'b1) begin bad++; $display("FAIL restart_ready: got %b want 1", ready_in); end
        @(negedge clk);
        #1;
        total++; if (valid_out !== 1'b1 || data_out !== word(0)) begin
            bad++; $display("FAIL restart_first: valid=%b data=%h want 1 %h", valid_out, data_out, word(0));
        end
        en = 1'b0;
        valid_in = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        obs_rd = obs_q.size();
    endtask

    task automatic test_async_reset();
        int k;
        apply_reset();
        k = 0;
        @(negedge clk);
        en = 1'b1;
        valid_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            data_in = word(k);
            #1;
            if (ready_in && valid_in) begin
                push_word(k);
                k++;
            end
        end
        total++; if (valid_out !== 1'b1 || data_out !== word(2)) begin
            bad++; $display("FAIL arst_pre: valid=%b data=%h want 1 %h", valid_out, data_out, word(2));
        end
        #1;
        rst = 1'b1;
        #1;
        total++; if (data_out !== '0) begin bad++; $display("FAIL arst_data: got %h want 0", data_out); end
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL arst_valid: got %b want 0", valid_out); end
        total++; if (ready_in !== 1'b0) begin bad++; $display("FAIL arst_ready: got %b want 0", ready_in); end
        en = 1'b0;
        valid_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        exp_q.delete();
        obs_rd = obs_q.size();
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b0;
        valid_in = 1'b0;
        data_in = '0;
        test_reset();
        test_basic_frame();
        test_handshake();
        test_bubbles();
        test_abort();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/unpool2_module.md
Name: unpool2_module

Overview:
- 2x2 nearest-neighbour upsampler. It is the inverse-direction counterpart of the 2x2 pool stage.
- Consumes a stream of 96-bit feature words: 12 lanes x 8 bit, one word per column, row-major.
- Emits each input word twice horizontally, then replays the buffered row once, so every input row yields two output rows of 2*COL_IN words.
- Sits on the decoder side of the accelerator, feeding the next conv stage.

Parameters:
- DATA_W, 96, width of one feature word (all lanes).
- COL_IN, 8, input words per row; output row is 2*COL_IN words.
- ROW_IN, 8, input rows per frame; output frame is 2*ROW_IN rows.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  block enable. Low aborts any frame.
- valid_in  input  1  data_in valid.
- data_in  input  DATA_W  input feature word.
- ready_in  output  1  block accepts data_in this cycle. Transfer occurs when valid_in && ready_in.
- data_out  output  DATA_W  output feature word, registered.
- valid_out  output  1  data_out valid, registered.
- unpool_end  output  1  one-cycle pulse after the last output word of a frame.

Behaviour:
- Reset values: data_out=0, valid_out=0, ready_in=0, unpool_end=0, state=IDLE. All counters and dup=0. Line buffer contents are don't-care.
- Line buffer: COL_IN x DATA_W registers.
- Counters: wcol/rcol 0..COL_IN-1; row_cnt 0..ROW_IN-1; dup 1 bit.
- ready_in = (state==FILL) && (dup==0) && en. It is combinational from registered state.

State IDLE:
- valid_out=0.
- en=1 -> FILL, with wcol=0 and row_cnt=0.

State FILL, dup=0:
- On handshake: buf[wcol]<=data_in, data_out<=data_in, valid_out<=1, dup<=1.
- Without handshake: valid_out<=0 (bubbles allowed).

State FILL, dup=1:
- No input is accepted.
- data_out holds, valid_out<=1 (second copy), dup<=0.
- If wcol==COL_IN-1: wcol<=0, go to REPLAY with rcol=0 and dup=0. Otherwise wcol++.

State REPLAY (ready_in=0):
- Each cycle: data_out<=buf[rcol], valid_out<=1.
- dup toggles each cycle; rcol++ when dup==1.
- Runs exactly 2*COL_IN cycles, with no bubbles.
- After the last word: if row_cnt==ROW_IN-1 -> DONE, otherwise row_cnt++ and go to FILL.

State DONE:
- valid_out<=0, unpool_end<=1 for one cycle, then IDLE.
- If en is still 1, IDLE restarts a new frame on the next cycle.

Timing:
- Latency: first copy appears 1 cycle after the handshake; second copy on the following cycle.
- Output words per frame: 4*COL_IN*ROW_IN (256 at defaults).
- Minimum frame time: 4*COL_IN*ROW_IN + 2 cycles.

Abort and reset:
- en=0 in any non-IDLE state: next cycle state=IDLE, valid_out=0, unpool_end=0, counters cleared. The partial frame is discarded and unpool_end is not pulsed.
- valid_in is ignored while ready_in=0. Upstream must hold data until the handshake completes.
- Reset mid-frame: immediate return to reset values, with no residual outputs.

Arithmetic:
- No arithmetic on data; words are copied bit-exact.
- Counter widths: $clog2 of their ranges, minimum 1.

Optional Feature:
- Macro: UNPOOL_ZERO_FILL_EN.
- Defined: zero-insertion upsampling. Only the top-left position of each 2x2 block carries data_in.
  - Second FILL copy outputs 0.
  - REPLAY outputs 0 for all 2*COL_IN words.
  - Line-buffer writes are compiled out.
  - Handshake, timing and counts are identical.
- Undefined: nearest-neighbour replication as described in Behaviour.

Test Plan:
- Basic frame:
  - Stimulus: reset, en=1, stream 64 words data_in={12{k[7:0]}} for k=0..63, valid_in held high.
  - Required: 256 valid_out words.
  - Output row 0 = k0,k0,k1,k1..k7,k7; row 1 identical to row 0.
  - unpool_end pulses exactly once, 1 cycle after the last word.
- Handshake:
  - Stimulus: valid_in high continuously.
  - Required: ready_in pattern 1,0 repeating for 16 cycles per row, then 0 for 16 REPLAY cycles.
  - No word is accepted while ready_in=0.
- Bubbles:
  - Stimulus: valid_in pseudo-random 50%.
  - Required: output data sequence identical to the basic-frame test; valid_out gaps appear only in FILL.
- Abort:
  - Stimulus: drop en at REPLAY word 5 of row 3.
  - Required: valid_out=0 the next cycle, no unpool_end.
  - Re-raising en starts a new frame; its first word k=0 appears 1 cycle after the handshake.
- Async reset:
  - Stimulus: assert rst mid-FILL between clock edges.
  - Required: data_out=0, valid_out=0 and ready_in=0 immediately, without waiting for a clock edge.
- Zero-fill build (UNPOOL_ZERO_FILL_EN defined):
  - Stimulus: the basic-frame stimulus.
  - Required: row 0 = k0,0,k1,0..k7,0; row 1 all zero; 256 words total.
